expr_string_tx: RTL and testbench
=================================

Name: expr_string_tx

Overview:
Serializer that drives ASCII expression strings (digits '0'-'9' joined by '+' or '*') into the expression-string recognizer, one character per accepted transfer.
- Latches up to MAX_OPS decimal operands and the operators between them on a start request.
- Emits a one-cycle recognizer clear, then the characters in order, then a done pulse.
- Sits upstream of the recognizer and drives its clr and in inputs. Used as a stimulus source and in self-checking loops.

Parameters:
MAX_OPS, 4, maximum number of operands per string (≥1)
IDX_W, 3, width of operand count/index; must satisfy 2**IDX_W > MAX_OPS

Ports:
clk  input  1  system clock, rising edge
clr  input  1  synchronous reset, active-low: clr==0 at a rising edge resets the block
start  input  1  request to send a string; sampled only in IDLE
n_ops  input  IDX_W  number of operands, valid range 1..MAX_OPS
digits  input  4*MAX_OPS  operand i at [4i+3:4i], binary 0..9; emitted for i = 0..n_ops-1
ops  input  MAX_OPS-1  bit i is the operator between operand i and i+1: 0 = '+' (8'd43), 1 = '*' (8'd42)
ch_ready  input  1  consumer accepts ch this cycle when ch_valid=1
busy  output  1  high from the cycle after acceptance through the DONE cycle
str_clr  output  1  active-high clear pulse for the recognizer
ch  output  8  ASCII character; 8'd0 whenever ch_valid=0
ch_valid  output  1  ch holds a character
done  output  1  one-cycle pulse after the last character is accepted
err  output  1  sticky: an operand >9 was emitted in the current or last string

Behaviour:
- Reset (clr==0 at an edge): state IDLE. busy, str_clr, ch, ch_valid, done and err are all 0. Latched registers are cleared.
- Reset mid-string aborts the string: no done pulse, all outputs 0 from the next cycle.
- States: IDLE, SYNC, DIGIT, OP, DONE.
- IDLE: start=1 with 1 ≤ n_ops ≤ MAX_OPS is accepted.
  - On acceptance, latch digits, ops and n_ops; set idx=0; clear err; go to SYNC.
  - An out-of-range n_ops (0 or >MAX_OPS) is ignored and the block stays in IDLE.
- SYNC (one cycle): str_clr=1, ch_valid=0, busy=1. Go to DIGIT unconditionally.
- DIGIT: ch_valid=1.
  - ch = 8'd48 + digit[idx]. If digit[idx] > 9, ch = 8'd63 ('?') and err is set (sticky).
  - Hold ch stable until ch_ready=1.
  - On acceptance: if idx == n_ops-1, go to DONE; else go to OP.
- OP: ch_valid=1, ch = ops[idx] ? 8'd42 : 8'd43. Hold until ch_ready=1.
  - On acceptance: idx ← idx+1, go to DIGIT.
- DONE (one cycle): done=1, busy=1, ch_valid=0. Go to IDLE.
- Transfer rules:
  - A transfer occurs on a rising edge with ch_valid=1 and ch_ready=1.
  - ch_ready is ignored when ch_valid=0.
  - There are no bubbles between characters when ch_ready stays high.
- Latency with ch_ready held at 1: acceptance edge, then 1 SYNC cycle, then 2·n_ops−1 character cycles, then 1 DONE cycle.
  - busy is low again on the cycle after DONE.
  - start may be re-asserted in that cycle and is accepted.
- start while busy is ignored, not queued.
- Changes to digits, ops or n_ops after acceptance have no effect on the string in flight.
- err keeps its value after DONE until the next accepted start or reset.
- n_ops=1 emits a single digit and no operator.

Test Plan:
- Reset: clr=0 for 2 cycles with start=1 → all outputs 0; no transfer occurs.
- n_ops=3, digits {3,2,1} (operand0=1), ops=2'b01, ch_ready=1 → str_clr for 1 cycle, then ch = 49,42,50,43,51 on consecutive cycles, then done=1 for 1 cycle. The recognizer downstream ends with out=1. err=0.
- Same string with ch_ready low for 3 cycles while ch=42 → ch stays 42 with ch_valid=1 for 4 cycles; the sequence is otherwise unchanged and nothing is duplicated.
- n_ops=1, digit0=7 → ch=55 once, then done. Then n_ops=0 with start → ignored, busy stays 0.
- digit1=12, n_ops=2, ops[0]=0 → chars 48+d0, 43, 63; err=1 from the '?' cycle onward and still 1 after done. The next accepted start clears err.
- clr=0 while in OP → outputs 0 at the next edge, no done pulse. A new start after release produces the full sequence from str_clr.

Source files
------------

// File: rtl/expr_string_tx.sv
// expr_string_tx: serializes a latched list of decimal operands and '+'/'*'
// operators into ASCII characters for the expression-string recognizer.
// Sequence per string: one recognizer clear cycle, the characters with a
// valid/ready handshake, then a one-cycle done pulse.
module expr_string_tx #(
    parameter int MAX_OPS = 4,
    parameter int IDX_W   = 3
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   start,
    input  logic [IDX_W-1:0]       n_ops,
    input  logic [4*MAX_OPS-1:0]   digits,
    input  logic [MAX_OPS-2:0]     ops,
    input  logic                   ch_ready,
    output logic                   busy,
    output logic                   str_clr,
    output logic [7:0]             ch,
    output logic                   ch_valid,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DIGIT,
        OP,
        DONE
    } state_t;

    // Operand/operator tables are padded to the full index range so any
    // idx value selects a defined entry without a width mismatch.
    localparam int              SLOTS = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] MAX_N = IDX_W'(MAX_OPS);

    state_t               state_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic [IDX_W-1:0]     n_ops_reg;
    logic [4*MAX_OPS-1:0] digits_reg;
    logic [MAX_OPS-2:0]   ops_reg;

    logic [3:0]           operand [SLOTS];
    logic [SLOTS-1:0]     op_vec;

    logic [IDX_W-1:0]     idx_inc;
    logic [3:0]           cur_digit;
    logic [3:0]           nxt_digit;
    logic                 last_operand;
    logic                 start_ok;

    // Unpack the latched operands and operators into index-addressable tables.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            if (gi < MAX_OPS) begin : g_operand
                assign operand[gi] = digits_reg[4*gi +: 4];
            end else begin : g_operand_pad
                assign operand[gi] = 4'd0;
            end
            if (gi < MAX_OPS - 1) begin : g_op
                assign op_vec[gi] = ops_reg[gi];
            end else begin : g_op_pad
                assign op_vec[gi] = 1'b0;
            end
        end
    endgenerate

    // ASCII for one operand; anything outside 0..9 becomes '?'.
    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return (d > 4'd9) ? 8'd63 : (8'd48 + {4'd0, d});
    endfunction

    // Current/next operand lookup and start qualification.
    always_comb begin
        idx_inc      = idx_reg + IDX_W'(1);
        cur_digit    = operand[idx_reg];
        nxt_digit    = operand[idx_inc];
        last_operand = (idx_reg == (n_ops_reg - IDX_W'(1)));
        start_ok     = start && (n_ops != '0) && (n_ops <= MAX_N);
    end

    // Sequencer with registered outputs: each transition loads the outputs
    // that belong to the state being entered.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            n_ops_reg  <= '0;
            digits_reg <= '0;
            ops_reg    <= '0;
            busy       <= 1'b0;
            str_clr    <= 1'b0;
            ch         <= 8'd0;
            ch_valid   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    busy     <= 1'b0;
                    str_clr  <= 1'b0;
                    ch       <= 8'd0;
                    ch_valid <= 1'b0;
                    done     <= 1'b0;
                    if (start_ok) begin
                        digits_reg <= digits;
                        ops_reg    <= ops;
                        n_ops_reg  <= n_ops;
                        idx_reg    <= '0;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        str_clr    <= 1'b1;
                        state_reg  <= SYNC;
                    end
                end
                SYNC: begin
                    // idx is 0 here, so cur_digit is the first operand.
                    str_clr   <= 1'b0;
                    ch_valid  <= 1'b1;
                    ch        <= digit_char(cur_digit);
                    if (cur_digit > 4'd9) begin
                        err <= 1'b1;
                    end
                    state_reg <= DIGIT;
                end
                DIGIT: begin
                    if (ch_ready) begin
                        if (last_operand) begin
                            ch_valid  <= 1'b0;
                            ch        <= 8'd0;
                            done      <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            ch        <= op_vec[idx_reg] ? 8'd42 : 8'd43;
                            state_reg <= OP;
                        end
                    end
                end
                OP: begin
                    if (ch_ready) begin
                        idx_reg   <= idx_inc;
                        ch        <= digit_char(nxt_digit);
                        if (nxt_digit > 4'd9) begin
                            err <= 1'b1;
                        end
                        state_reg <= DIGIT;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    str_clr   <= 1'b0;
                    ch        <= 8'd0;
                    ch_valid  <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_expr_string_tx.sv
// Testbench for expr_string_tx: directed strings plus randomized strings with
// random back-pressure, checked against an expected character list built from
// the operand/operator values.
module tb_expr_string_tx;

    localparam int MAX_OPS = 4;
    localparam int IDX_W   = 3;

    logic                 clk = 1'b0;
    logic                 clr;
    logic                 start;
    logic [IDX_W-1:0]     n_ops;
    logic [4*MAX_OPS-1:0] digits;
    logic [MAX_OPS-2:0]   ops;
    logic                 ch_ready;
    logic                 busy;
    logic                 str_clr;
    logic [7:0]           ch;
    logic                 ch_valid;
    logic                 done;
    logic                 err;

    int checks      = 0;
    int miscompares = 0;

    expr_string_tx #(
        .MAX_OPS(MAX_OPS),
        .IDX_W  (IDX_W)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .n_ops   (n_ops),
        .digits  (digits),
        .ops     (ops),
        .ch_ready(ch_ready),
        .busy    (busy),
        .str_clr (str_clr),
        .ch      (ch),
        .ch_valid(ch_valid),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_str_clr"}, 32'(str_clr), 0);
        chk({tag, "_ch"}, 32'(ch), 0);
        chk({tag, "_ch_valid"}, 32'(ch_valid), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    // Sends one string and checks every cycle of it. Called when the DUT is
    // idle; returns one cycle after the done pulse (busy expected low).
    task automatic run_string(input int n, input logic [15:0] dg, input logic [2:0] op,
                              input int pct, input int stall_at, input int stall_len,
                              input bit rnd_start);
        byte unsigned exp_q[$];
        bit           err_exp;
        bit           rdy;
        int           k;
        int           cyc;
        int           stalled;
        int           d;

        exp_q = {};
        for (int i = 0; i < n; i++) begin
            d = int'(dg[4*i +: 4]);
            exp_q.push_back((d > 9) ? 8'd63 : byte'(48 + d));
            if (i < n - 1) exp_q.push_back(op[i] ? 8'd42 : 8'd43);
        end

        n_ops    = IDX_W'(n);
        digits   = dg;
        ops      = op;
        start    = 1'b1;
        ch_ready = 1'($urandom_range(0, 1));
        tick();

        // Input changes after acceptance must not reach the string in flight.
        start  = 1'b0;
        n_ops  = IDX_W'($urandom);
        digits = 16'($urandom);
        ops    = 3'($urandom);
        chk("sync_str_clr", 32'(str_clr), 1);
        chk("sync_busy", 32'(busy), 1);
        chk("sync_ch_valid", 32'(ch_valid), 0);
        chk("sync_ch", 32'(ch), 0);
        chk("sync_err", 32'(err), 0);
        ch_ready = 1'($urandom_range(0, 1));
        tick();

        k = 0;
        cyc = 0;
        stalled = 0;
        err_exp = 1'b0;
        while (k < exp_q.size() && cyc < 400) begin
            if (exp_q[k] == 8'd63) err_exp = 1'b1;
            chk("char_valid", 32'(ch_valid), 1);
            chk("char_value", 32'(ch), 32'(exp_q[k]));
            chk("char_busy", 32'(busy), 1);
            chk("char_str_clr", 32'(str_clr), 0);
            chk("char_done", 32'(done), 0);
            chk("char_err", 32'(err), 32'(err_exp));
            rdy = ($urandom_range(0, 99) < pct);
            if (k == stall_at && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end
            ch_ready = rdy;
            if (rnd_start) begin
                start = 1'($urandom_range(0, 1));
                n_ops = IDX_W'($urandom_range(1, MAX_OPS));
            end
            if (rdy) k++;
            cyc++;
            tick();
        end
        chk("char_count", 32'(k), 32'(exp_q.size()));

        chk("done_pulse", 32'(done), 1);
        chk("done_busy", 32'(busy), 1);
        chk("done_ch_valid", 32'(ch_valid), 0);
        chk("done_ch", 32'(ch), 0);
        chk("done_err", 32'(err), 32'(err_exp));
        ch_ready = 1'($urandom_range(0, 1));
        tick();

        start = 1'b0;
        chk_idle_outputs("post");
        chk("post_err", 32'(err), 32'(err_exp));
        $display("string n=%0d digits=%h ops=%b pct=%0d chars=%0d err=%0d", n, dg, op, pct,
                 exp_q.size(), err_exp);
    endtask

    initial begin
        logic [15:0] rd;
        int          rn;

        // Reset held with start asserted: nothing may begin.
        clr      = 1'b0;
        start    = 1'b1;
        n_ops    = 3'd3;
        digits   = 16'h0321;
        ops      = 3'b001;
        ch_ready = 1'b1;
        tick();
        tick();
        chk_idle_outputs("reset");
        chk("reset_err", 32'(err), 0);
        $display("reset held 2 cycles with start=1");
        clr   = 1'b1;
        start = 1'b0;
        tick();

        // "1*2+3" with no back-pressure.
        run_string(3, 16'h0321, 3'b001, 100, -1, 0, 1'b0);

        // Same string, '*' held off for 3 cycles.
        run_string(3, 16'h0321, 3'b001, 100, 1, 3, 1'b0);

        // Single operand, no operator.
        run_string(1, 16'h0007, 3'b000, 100, -1, 0, 1'b0);

        // Out-of-range operand counts are ignored.
        start = 1'b1;
        n_ops = 3'd0;
        tick();
        chk("nops0_busy", 32'(busy), 0);
        chk("nops0_str_clr", 32'(str_clr), 0);
        n_ops = 3'd5;
        tick();
        chk("nops5_busy", 32'(busy), 0);
        chk("nops5_str_clr", 32'(str_clr), 0);
        start = 1'b0;
        tick();
        chk("nops_idle_busy", 32'(busy), 0);
        $display("start with n_ops=0 and n_ops=5 ignored");

        // Operand above 9 shows as '?' and sets the sticky error.
        run_string(2, 16'h00C5, 3'b000, 100, -1, 0, 1'b0);
        // The next accepted start clears it.
        run_string(2, 16'h0045, 3'b001, 100, -1, 0, 1'b0);

        // Reset while the operator is on the wire aborts the string.
        n_ops    = 3'd3;
        digits   = 16'h0321;
        ops      = 3'b001;
        start    = 1'b1;
        ch_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("abort_digit", 32'(ch), 49);
        tick();
        chk("abort_op", 32'(ch), 42);
        clr      = 1'b0;
        ch_ready = 1'b0;
        tick();
        chk_idle_outputs("abort");
        chk("abort_err", 32'(err), 0);
        clr = 1'b1;
        tick();
        chk_idle_outputs("abort_after");
        $display("reset during operator aborted string");
        run_string(3, 16'h0321, 3'b001, 100, -1, 0, 1'b0);

        // Randomized strings with random back-pressure and start noise.
        for (int t = 0; t < 30; t++) begin
            rd = '0;
            rn = $urandom_range(1, MAX_OPS);
            for (int i = 0; i < MAX_OPS; i++) begin
                if ($urandom_range(0, 7) == 0) rd[4*i +: 4] = 4'($urandom_range(10, 15));
                else rd[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            run_string(rn, rd, 3'($urandom), $urandom_range(30, 100), -1, 0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", checks, miscompares);
        $finish;
    end

endmodule
